if_prefetch: RTL and testbench

- Parametrised successor to the single-register fetch stage.
- Issues instruction-memory requests through a valid/ready handshake, tolerates multi-cycle in-order responses, and buffers fetched words in a small FIFO.
- Presents {pc, inst} pairs to decode through a valid/ready handshake.
- Handles branch and exception redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fifo.sv | 55 +++++
 rtl/if_prefetch.sv | 183 ++++++++++++++++++
 tb/tb_if_prefetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/clear; DEPTH must be a power of two.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  entry_t                     i_push_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output entry_t                     o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear && !rst) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/if_prefetch.sv
// Prefetching instruction-fetch stage: credit-limited request issue, in-order responses,
// redirect flush with stale-response dropping. IF_PERF_CNT_EN adds performance counters.
module if_prefetch
  import if_pkg::*;
#(
  parameter int unsigned      XLEN       = XLEN_DEFAULT,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0]  EXC_VECTOR = XLEN'(EXC_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            br,
  input  logic [XLEN-1:0] pc_branch,
  input  logic            except,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall,
`endif
  input  logic            out_ready
);

  localparam int unsigned     CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     SW         = CW + 1;
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } pf_entry_t;

  if_state_e       r_state;
  if_state_e       w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [XLEN-1:0] w_target;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_outstanding_next;
  logic [CW-1:0]   w_drop_next;
  logic [CW-1:0]   w_fifo_count;
  logic            w_redirect;
  logic            w_credit;
  logic            w_fire;
  logic            w_rsp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  pf_entry_t       w_push_data;
  pf_entry_t       w_head;

  // Redirect decode: exception wins over branch; target always word aligned.
  assign w_redirect = br || except;
  assign w_target   = (except ? EXC_VECTOR : pc_branch) & ALIGN_MASK;

  assign w_credit = (SW'(w_fifo_count) + SW'(r_outstanding)) < SW'(FIFO_DEPTH);
  assign w_fire   = imem_req_valid && imem_req_ready;

  // Responses arriving with nothing outstanding (e.g. after reset) are ignored.
  assign w_rsp  = imem_rsp_valid && (r_outstanding != '0);
  assign w_drop = w_rsp && (w_redirect || (r_drop_cnt != '0));
  assign w_push = w_rsp && !w_drop;
  assign w_pop  = out_valid && out_ready && !w_redirect;

  assign w_push_data.pc   = r_rsp_pc;
  assign w_push_data.inst = imem_rsp_data;

  assign w_outstanding_next = r_outstanding + CW'(w_fire) - CW'(w_rsp);

  always_comb begin
    w_drop_next = r_drop_cnt;
    if (w_redirect) begin
      w_drop_next = r_outstanding - CW'(w_rsp);
    end else if (w_rsp && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:       w_state_next = RUN;
      RUN, FLUSH: w_state_next = (w_drop_next != '0) ? FLUSH : RUN;
      default:    w_state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req_valid = 1'b0;
    case (r_state)
      RUN, FLUSH: imem_req_valid = w_credit && !w_redirect;
      default:    imem_req_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= w_drop_next;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + PC_INC;
        if (w_push) r_rsp_pc   <= r_rsp_pc + PC_INC;
      end
    end
  end

  assign imem_req_addr = r_fetch_pc;

  if_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (pf_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_clear     (w_redirect),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Head storage is not reset, so hide it while empty.
  assign out_valid = !w_empty;
  assign out_pc    = w_empty ? '0 : w_head.pc;
  assign out_inst  = w_empty ? '0 : w_head.inst;

  // The credit rule keeps a push from ever landing on a full, non-draining buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(w_push && w_full && !w_pop));

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_fire)                  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_drop)                  r_perf_dropped <= r_perf_dropped + 32'd1;
      if (out_valid && !out_ready) r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: vector table plus hand-written redirect/stall/reset sequences.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        br;
  logic [31:0] pc_branch;
  logic        except;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  if_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .br             (br),
    .pc_branch      (pc_branch),
    .except         (except),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
`ifdef IF_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_stall     (perf_stall),
`endif
    .out_ready      (out_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        ordy;
    logic        br;
    logic        exc;
    logic [31:0] pcb;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mq[$];
  vec_t        vecs[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic        mon_en = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] exp_next = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory response for the current cycle, then let combinational outputs settle.
  task automatic apply();
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mq[0].addr);
      void'(mq.pop_front());
    end else if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  // Record handshakes seen this cycle, then advance to the next negedge.
  task automatic clock();
    if (rst) mq.delete();
    else if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
    if (mon_en && out_valid && out_ready && !br && !except) begin
      check($sformatf("mon.pc#%0d", n_out), out_pc, exp_next);
      check($sformatf("mon.inst#%0d", n_out), out_inst, inst_of(exp_next));
      exp_next = exp_next + 32'd4;
      n_out++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; br = 1'b0; except = 1'b0; pc_branch = '0; stray = 1'b0; mon_en = 1'b0;
    repeat (2) begin apply(); clock(); end
    rst = 1'b0;
  endtask

  task automatic add(input logic r, input logic rdy, input logic ordy, input logic b, input logic e,
                     input logic [31:0] pcb, input logic rv, input logic [31:0] addr,
                     input logic ov, input logic [31:0] pc);
    vecs.push_back('{r, rdy, ordy, b, e, pcb, rv, addr, ov, pc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    br = 1'b0; except = 1'b0; pc_branch = '0; out_ready = 1'b1;

    //   rst rdy ordy br  exc pcb           rv  addr          ov  pc
    // Streaming with 1-cycle memory; first out_valid three edges after reset release.
    add(1, 1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'hC,        1, 32'h4);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h8);
    // Reset is synchronous: outputs clear only after the edge.
    add(1, 1, 0, 0, 0, 32'h0,        1, 32'h14,       1, 32'hC);
    add(1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    // Decode stalled: buffer fills to 4, issue stops, then drains in order.
    add(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        1, 32'hC,        1, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        0, 32'h10,       1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h4);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h14,       1, 32'h8);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h18,       1, 32'hC);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h1C,       1, 32'h10);
    // Branch and exception together: exception vector wins, no pop this cycle.
    add(0, 1, 1, 1, 1, 32'h40,       0, 32'h20,       1, 32'h14);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h8000_0180, 0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h8000_0184, 0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h8000_0188, 1, 32'h8000_0180);

    @(negedge clk);
    lat = 1;
    do_reset();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; imem_req_ready = vecs[i].ready; out_ready = vecs[i].ordy;
      br = vecs[i].br; except = vecs[i].exc; pc_branch = vecs[i].pcb;
      apply();
      check($sformatf("v%0d.req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
      check($sformatf("v%0d.req_addr", i), imem_req_addr, vecs[i].exp_addr);
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d.out_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("v%0d.out_inst", i), out_inst,
            vecs[i].exp_ov ? inst_of(vecs[i].exp_pc) : 32'h0);
      clock();
    end
    br = 1'b0; except = 1'b0;

    // Branch with three requests in flight on a 3-cycle memory; misaligned target.
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    mon_en = 1'b1; exp_next = 32'h100; n_out = 0;
    repeat (4) begin apply(); clock(); end
    br = 1'b1; pc_branch = 32'h103;
    apply();
    check("seqA.redirect_req_valid", 32'(imem_req_valid), 32'h0);
    clock();
    br = 1'b0;
    apply();
    check("seqA.target_addr", imem_req_addr, 32'h100);
    check("seqA.target_valid", 32'(imem_req_valid), 32'h1);
    clock();
    repeat (20) begin apply(); clock(); end
    check("seqA.outputs_seen", 32'(n_out >= 8), 32'h1);
`ifdef IF_PERF_CNT_EN
    check("seqA.perf_dropped", perf_dropped, 32'd3);
`endif

    // Memory back-pressure: address held, PC frozen, stream stays gap-free.
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    mon_en = 1'b1; exp_next = 32'h0; n_out = 0;
    repeat (4) begin apply(); clock(); end
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply();
      check($sformatf("seqB.stall%0d.valid", k), 32'(imem_req_valid), 32'h1);
      check($sformatf("seqB.stall%0d.addr", k), imem_req_addr, 32'hC);
      clock();
    end
    imem_req_ready = 1'b1;
    apply();
    check("seqB.resume_addr", imem_req_addr, 32'hC);
`ifdef IF_PERF_CNT_EN
    check("seqB.perf_fetched", perf_fetched, 32'd3);
    check("seqB.perf_stall", perf_stall, 32'd0);
`endif
    clock();
    repeat (10) begin apply(); clock(); end
    check("seqB.outputs_seen", 32'(n_out >= 10), 32'h1);

    // Reset with two entries buffered and two requests in flight.
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b0;
    repeat (6) begin apply(); clock(); end
    rst = 1'b1;
    apply();
    check("seqC.pre_out_valid", 32'(out_valid), 32'h1);
    check("seqC.pre_out_pc", out_pc, 32'h0);
    check("seqC.pre_req_valid", 32'(imem_req_valid), 32'h0);
    clock();
    rst = 1'b0; stray = 1'b1;
    apply();
    check("seqC.rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("seqC.rst_req_addr", imem_req_addr, 32'h0);
    check("seqC.rst_out_valid", 32'(out_valid), 32'h0);
    check("seqC.rst_out_pc", out_pc, 32'h0);
    check("seqC.rst_out_inst", out_inst, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("seqC.rst_perf_fetched", perf_fetched, 32'd0);
    check("seqC.rst_perf_dropped", perf_dropped, 32'd0);
    check("seqC.rst_perf_stall", perf_stall, 32'd0);
`endif
    clock();
    stray = 1'b0; lat = 1; out_ready = 1'b1;
    mon_en = 1'b1; exp_next = 32'h0; n_out = 0;
    apply();
    check("seqC.restart_valid", 32'(imem_req_valid), 32'h1);
    check("seqC.restart_addr", imem_req_addr, 32'h0);
    check("seqC.stray_ignored", 32'(out_valid), 32'h0);
    clock();
    repeat (6) begin apply(); clock(); end
    check("seqC.outputs_seen", 32'(n_out >= 3), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
